// File: rtl/id_pipe_pkg.sv
// Shared opcode encoding, decode-stage FSM states and instruction field offsets
// for the registered instruction decode stage.
package id_pipe_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_AND = 4'h2,
        OP_OR  = 4'h3,
        OP_XOR = 4'h4,
        OP_NOT = 4'h5,
        OP_SHL = 4'h6,
        OP_SHR = 4'h7,
        OP_NOP = 4'h8,
        OP_STM = 4'h9,
        OP_ST  = 4'hA,
        OP_LDM = 4'hB,
        OP_LD  = 4'hC
    } full_operation_t;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_LD_HOLD = 2'd1,
        S_LD_WAIT = 2'd2
    } id_state_t;

    localparam int OPCODE_W        = 4;
    // Direct-load flag sits this many bits above the RF address field.
    localparam int DIRECT_FLAG_OFS = 5;

endpackage

// File: rtl/id_decode_comb.sv
// Pure combinational decode of one instruction word into the datapath control bundle.
// Unused opcodes behave as ALU operations and load the accumulator.
module id_decode_comb
    import id_pipe_pkg::*;
#(
    parameter int RF_AW = 2,
    parameter int DM_AW = 10,
    parameter int DW    = 8,
    localparam int IW     = DM_AW + OPCODE_W + RF_AW,
    localparam int NUM_RF = 2 ** RF_AW
) (
    input  logic [IW-1:0]     i_instruction,
    output logic [2:0]        o_operation_code,
    output logic [RF_AW-1:0]  o_register_file_addr,
    output logic [NUM_RF-1:0] o_register_file_we,
    output logic              o_acumulator_ce,
    output logic [DM_AW-1:0]  o_data_memory_addr,
    output logic              o_memory_write_enable,
    output logic              o_memory_read_enable,
    output logic [DW-1:0]     o_direct_data,
    output logic              o_direct_load,
    output logic              o_is_ldm
);

    logic [OPCODE_W-1:0] w_opcode;
    full_operation_t     w_op;

    assign w_opcode = i_instruction[RF_AW+OPCODE_W-1:RF_AW];
    assign w_op     = full_operation_t'(w_opcode);

    always_comb begin
        o_operation_code      = w_opcode[2:0];
        o_register_file_addr  = i_instruction[RF_AW-1:0];
        o_data_memory_addr    = i_instruction[IW-1 -: DM_AW];
        o_register_file_we    = '0;
        o_acumulator_ce       = 1'b0;
        o_memory_write_enable = 1'b0;
        o_memory_read_enable  = 1'b0;
        o_direct_data         = '0;
        o_direct_load         = 1'b0;
        o_is_ldm              = 1'b0;
        case (w_op)
            OP_NOP: ;
            OP_STM: o_memory_write_enable = 1'b1;
            OP_ST:  o_register_file_we[i_instruction[RF_AW-1:0]] = 1'b1;
            OP_LDM: begin
                o_acumulator_ce      = 1'b1;
                o_memory_read_enable = 1'b1;
                o_is_ldm             = 1'b1;
            end
            OP_LD: begin
                o_acumulator_ce = 1'b1;
                if (i_instruction[RF_AW+DIRECT_FLAG_OFS]) begin
                    o_direct_load = 1'b1;
                    o_direct_data = i_instruction[IW-1 -: DW];
                end
            end
            default: o_acumulator_ce = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_pipe.sv
// Registered decode stage: one control bundle per accepted word, and a front-end
// stall after OP_LDM until the data-memory read latency has elapsed.
module id_pipe
    import id_pipe_pkg::*;
#(
    parameter int RF_AW      = 2,
    parameter int DM_AW      = 10,
    parameter int DW         = 8,
    parameter int MEM_RD_LAT = 2,
    localparam int IW     = DM_AW + OPCODE_W + RF_AW,
    localparam int NUM_RF = 2 ** RF_AW
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [IW-1:0]     i_instruction,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [2:0]        o_operation_code,
    output logic [RF_AW-1:0]  o_register_file_addr,
    output logic [NUM_RF-1:0] o_register_file_we,
    output logic              o_acumulator_ce,
    output logic [DM_AW-1:0]  o_data_memory_addr,
    output logic              o_memory_write_enable,
    output logic              o_memory_read_enable,
    output logic [DW-1:0]     o_direct_data,
    output logic              o_direct_load,
    output logic              o_ld_pending
);

    localparam int CNT_W = $clog2(MEM_RD_LAT + 1);

    logic [2:0]        w_operation_code;
    logic [RF_AW-1:0]  w_register_file_addr;
    logic [NUM_RF-1:0] w_register_file_we;
    logic              w_acumulator_ce;
    logic [DM_AW-1:0]  w_data_memory_addr;
    logic              w_memory_write_enable;
    logic              w_memory_read_enable;
    logic [DW-1:0]     w_direct_data;
    logic              w_direct_load;
    logic              w_is_ldm;

    id_state_t         r_state;
    id_state_t         w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              r_valid;
    logic              w_accept;
    logic              w_consume;

    id_decode_comb #(
        .RF_AW (RF_AW),
        .DM_AW (DM_AW),
        .DW    (DW)
    ) u_decode (
        .i_instruction         (i_instruction),
        .o_operation_code      (w_operation_code),
        .o_register_file_addr  (w_register_file_addr),
        .o_register_file_we    (w_register_file_we),
        .o_acumulator_ce       (w_acumulator_ce),
        .o_data_memory_addr    (w_data_memory_addr),
        .o_memory_write_enable (w_memory_write_enable),
        .o_memory_read_enable  (w_memory_read_enable),
        .o_direct_data         (w_direct_data),
        .o_direct_load         (w_direct_load),
        .o_is_ldm              (w_is_ldm)
    );

    // Handshake: a word transfers on i_valid && o_ready, a bundle on o_valid && i_ready;
    // the bundle is held unchanged while o_valid && !i_ready, and o_ready is low in reset.
    assign o_ready      = !i_rst && (r_state == S_RUN) && (!r_valid || i_ready);
    assign w_accept     = i_valid && o_ready;
    assign w_consume    = r_valid && i_ready;
    assign o_valid      = r_valid;
    assign o_ld_pending = (r_state != S_RUN);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_RUN: begin
                if (w_accept && w_is_ldm) w_state_next = S_LD_HOLD;
            end
            S_LD_HOLD: begin
                if (w_consume) begin
                    w_state_next = S_LD_WAIT;
                    w_cnt_next   = CNT_W'(MEM_RD_LAT - 1);
                end
            end
            S_LD_WAIT: begin
                if (r_cnt == '0) w_state_next = S_RUN;
                else             w_cnt_next   = r_cnt - 1'b1;
            end
            default: w_state_next = S_RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid               <= 1'b0;
            o_operation_code      <= '0;
            o_register_file_addr  <= '0;
            o_register_file_we    <= '0;
            o_acumulator_ce       <= 1'b0;
            o_data_memory_addr    <= '0;
            o_memory_write_enable <= 1'b0;
            o_memory_read_enable  <= 1'b0;
            o_direct_data         <= '0;
            o_direct_load         <= 1'b0;
        end else if (w_accept) begin
            r_valid               <= 1'b1;
            o_operation_code      <= w_operation_code;
            o_register_file_addr  <= w_register_file_addr;
            o_register_file_we    <= w_register_file_we;
            o_acumulator_ce       <= w_acumulator_ce;
            o_data_memory_addr    <= w_data_memory_addr;
            o_memory_write_enable <= w_memory_write_enable;
            o_memory_read_enable  <= w_memory_read_enable;
            o_direct_data         <= w_direct_data;
            o_direct_load         <= w_direct_load;
        end else if (w_consume) begin
            // Drop strobes so a stale bundle can never fire twice downstream.
            r_valid               <= 1'b0;
            o_register_file_we    <= '0;
            o_acumulator_ce       <= 1'b0;
            o_memory_write_enable <= 1'b0;
            o_memory_read_enable  <= 1'b0;
            o_direct_load         <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_pipe.sv
// Bench for id_pipe: directed scenarios plus a randomized stream, every cycle checked
// against a transaction-level model of the decode rules and the LDM stall window.
module tb_id_pipe;
    import id_pipe_pkg::*;

    localparam int LAT = 2;
    localparam int BW  = 31;
    localparam logic [BW-1:0] STROBE_MASK = 31'h03E0_0601;

    logic        clk = 1'b0;
    logic        i_rst, i_valid, i_ready;
    logic [15:0] i_instruction;
    logic        o_ready, o_valid, o_acumulator_ce, o_memory_write_enable;
    logic        o_memory_read_enable, o_direct_load, o_ld_pending;
    logic [2:0]  o_operation_code;
    logic [1:0]  o_register_file_addr;
    logic [3:0]  o_register_file_we;
    logic [9:0]  o_data_memory_addr;
    logic [7:0]  o_direct_data;

    int total = 0;
    int bad   = 0;

    bit             m_valid;
    logic [BW-1:0]  m_bundle;
    bit             m_ldm;
    int             m_wait;

    logic [BW-1:0] dut_bundle;
    logic [7:0]    dut_strobes;

    always #5 clk = ~clk;

    id_pipe #(.MEM_RD_LAT(LAT)) dut (
        .i_clk                 (clk),
        .i_rst                 (i_rst),
        .i_instruction         (i_instruction),
        .i_valid               (i_valid),
        .o_ready               (o_ready),
        .o_valid               (o_valid),
        .i_ready               (i_ready),
        .o_operation_code      (o_operation_code),
        .o_register_file_addr  (o_register_file_addr),
        .o_register_file_we    (o_register_file_we),
        .o_acumulator_ce       (o_acumulator_ce),
        .o_data_memory_addr    (o_data_memory_addr),
        .o_memory_write_enable (o_memory_write_enable),
        .o_memory_read_enable  (o_memory_read_enable),
        .o_direct_data         (o_direct_data),
        .o_direct_load         (o_direct_load),
        .o_ld_pending          (o_ld_pending)
    );

    assign dut_bundle  = {o_operation_code, o_register_file_addr, o_register_file_we,
                          o_acumulator_ce, o_data_memory_addr, o_memory_write_enable,
                          o_memory_read_enable, o_direct_data, o_direct_load};
    assign dut_strobes = {o_register_file_we, o_acumulator_ce, o_memory_write_enable,
                          o_memory_read_enable, o_direct_load};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mkw(input logic [9:0] dm, input logic [3:0] opc,
                                        input logic [1:0] rf);
        return {dm, opc, rf};
    endfunction

    // Reference decode straight from the opcode table, default 16-bit layout.
    function automatic logic [BW-1:0] ref_decode(input logic [15:0] w);
        logic [3:0] opc;
        logic [3:0] we;
        logic       ce, mwe, mre, dl;
        logic [7:0] dd;
        opc = w[5:2];
        we = 4'b0; ce = 1'b0; mwe = 1'b0; mre = 1'b0; dl = 1'b0; dd = 8'h00;
        if (opc == OP_NOP) begin
        end else if (opc == OP_STM) begin
            mwe = 1'b1;
        end else if (opc == OP_ST) begin
            we = 4'b0001 << w[1:0];
        end else if (opc == OP_LDM) begin
            ce = 1'b1; mre = 1'b1;
        end else if (opc == OP_LD) begin
            ce = 1'b1;
            if (w[7]) begin
                dl = 1'b1; dd = w[15:8];
            end
        end else begin
            ce = 1'b1;
        end
        return {opc[2:0], w[1:0], we, ce, w[15:6], mwe, mre, dd, dl};
    endfunction

    // One clock: drive inputs, check outputs at the falling edge, advance the model.
    task automatic cycle(input bit rst, input bit v, input logic [15:0] w, input bit r,
                         output bit acc);
        bit exp_ready;
        bit cons;
        i_rst = rst; i_valid = v; i_instruction = w; i_ready = r;
        @(negedge clk);
        exp_ready = !rst && !m_ldm && (m_wait == 0) && (!m_valid || r);
        check("ready", 64'(o_ready), 64'(exp_ready));
        check("ld_pending", 64'(o_ld_pending), 64'(m_ldm || m_wait > 0));
        check("valid", 64'(o_valid), 64'(m_valid));
        if (m_valid) check("bundle", 64'(dut_bundle), 64'(m_bundle));
        else         check("idle_strobes", 64'(dut_strobes), 64'(0));
        acc  = v && exp_ready;
        cons = m_valid && r;
        if (rst) begin
            m_valid = 0; m_ldm = 0; m_wait = 0; m_bundle = '0;
        end else begin
            if (m_wait > 0) m_wait--;
            if (m_ldm && cons) begin
                m_ldm = 0; m_wait = LAT;
            end
            if (acc) begin
                m_valid  = 1;
                m_bundle = ref_decode(w);
                if (w[5:2] == OP_LDM) m_ldm = 1;
            end else if (cons) begin
                m_valid  = 0;
                m_bundle = m_bundle & ~STROBE_MASK;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Offer a word with i_ready=1 until taken; reports the cycles spent waiting.
    task automatic push(input logic [15:0] w, output int waited);
        bit acc;
        acc = 0; waited = 0;
        while (!acc && waited < 50) begin
            cycle(0, 1, w, 1, acc);
            if (!acc) waited++;
        end
        if (!acc) check("push_timeout", 64'(acc), 64'(1));
    endtask

    initial begin
        int  waited;
        bit  acc;
        bit  have;
        logic [15:0] pend;
        logic [3:0]  opc;

        m_valid = 0; m_ldm = 0; m_wait = 0; m_bundle = '0;
        i_rst = 1; i_valid = 1; i_ready = 1; i_instruction = 16'h0000;
        @(posedge clk);
        #1;

        // Reset held with a valid word on the input
        cycle(1, 1, mkw(10'h155, OP_ADD, 2'd1), 1, acc);
        cycle(1, 1, mkw(10'h155, OP_ADD, 2'd1), 1, acc);

        // Back-to-back ALU stream
        for (int i = 0; i < 4; i++) begin
            push(mkw(10'($urandom), 4'(i + 1), 2'($urandom)), waited);
            check("alu_no_bubble", 64'(waited), 64'(0));
        end

        // Register store, memory store, nop
        push(mkw(10'h000, OP_ST, 2'd3), waited);
        push(mkw(10'h2A5, OP_STM, 2'd0), waited);
        push(mkw(10'h3FF, OP_NOP, 2'd2), waited);

        // Direct load with and without the flag
        push(mkw({8'hC3, 2'b10}, OP_LD, 2'd1), waited);
        push(mkw({8'hC3, 2'b00}, OP_LD, 2'd1), waited);
        cycle(0, 0, 16'h0, 1, acc);

        // LDM followed by an ALU word, consumer always ready
        push(mkw(10'h12C, OP_LDM, 2'd0), waited);
        push(mkw(10'h001, OP_XOR, 2'd2), waited);
        check("ldm_stall", 64'(waited), 64'(LAT + 1));

        // LDM with the consumer stalling three cycles
        push(mkw(10'h0F0, OP_LDM, 2'd1), waited);
        for (int i = 0; i < 3; i++) cycle(0, 1, mkw(10'h002, OP_SUB, 2'd0), 0, acc);
        push(mkw(10'h002, OP_SUB, 2'd0), waited);
        check("ldm_stall_bp", 64'(waited), 64'(LAT + 1));
        cycle(0, 0, 16'h0, 1, acc);

        // Backpressure then reset in the middle of the latency wait
        push(mkw(10'h333, OP_LDM, 2'd3), waited);
        cycle(0, 1, mkw(10'h004, OP_AND, 2'd1), 0, acc);
        cycle(0, 1, mkw(10'h004, OP_AND, 2'd1), 0, acc);
        cycle(0, 1, mkw(10'h004, OP_AND, 2'd1), 1, acc);
        cycle(0, 1, mkw(10'h004, OP_AND, 2'd1), 0, acc);
        cycle(1, 1, mkw(10'h004, OP_AND, 2'd1), 0, acc);
        push(mkw(10'h004, OP_AND, 2'd1), waited);
        check("after_reset_no_stall", 64'(waited), 64'(0));

        // Randomized traffic; a refused word is held until taken
        have = 0; pend = '0;
        for (int i = 0; i < 600; i++) begin
            if (!have && $urandom_range(0, 9) < 7) begin
                opc  = ($urandom_range(0, 4) == 0) ? 4'(OP_LDM) : 4'($urandom_range(0, 15));
                pend = mkw(10'($urandom), opc, 2'($urandom));
                have = 1;
            end
            cycle($urandom_range(0, 99) == 0, have, pend, $urandom_range(0, 3) != 0, acc);
            if (acc) have = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
